shreg_sequencer: RTL and testbench
==================================

# shreg_sequencer

Command-driven controller for the 8-bit universal shift register (hold / shift-left / parallel-load / shift-right). It accepts one operation at a time over a valid/ready handshake and drives the register's mode select, serial input and enable for the required number of cycles. It also generates rotate feedback from the register output and reports completion. It sits between a host or bus-side FSM and the register instance, and is the only agent that writes the register.

## Interface
Parameters:
- WIDTH, 8, register width in bits
- CNT_W, $clog2(WIDTH) (3), width of the step-count field

Ports:
- CLOCK  in  1  clock, rising edge
- RESET  in  1  reset RESET, synchronous, active-high; clock CLOCK
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_op  in  3  operation: 0 LOAD, 1 SHL, 2 SHR, 3 ROTL, 4 ROTR, 5 CLEAR, 6/7 illegal
- cmd_count  in  CNT_W  shift steps minus one (shifts = cmd_count+1, range 1..WIDTH); ignored for LOAD/CLEAR
- cmd_data  in  WIDTH  parallel data for LOAD
- ser_in  in  1  external serial bit for SHL/SHR, sampled live each RUN cycle
- reg_q  in  WIDTH  register output, used for rotate feedback and ser_out
- reg_ctrl  out  2  register mode: 00 hold, 01 shift toward MSB, 10 load, 11 shift toward LSB
- reg_sin  out  1  register serial input
- reg_d  out  WIDTH  register parallel input
- reg_en  out  1  register enable
- ser_out  out  1  bit leaving the register this cycle (reg_q[WIDTH-1] for SHL/ROTL, reg_q[0] for SHR/ROTR, else 0)
- ser_out_valid  out  1  high in RUN cycles of a shift/rotate
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; high for an illegal op

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1, reg_en=0, reg_ctrl=00.
  - On cmd_valid&cmd_ready, latch op, count and data.
  - Legal op: go to RUN with step counter = cmd_count (shifts) or 0 (LOAD/CLEAR).
  - Illegal op: go directly to DONE with err=1. The register is never enabled.
- RUN: reg_en=1; per op:
  - LOAD: reg_ctrl=10, reg_d=latched data.
  - CLEAR: reg_ctrl=10, reg_d=0.
  - SHL: reg_ctrl=01, reg_sin=ser_in.
  - SHR: reg_ctrl=11, reg_sin=ser_in.
  - ROTL: reg_ctrl=01, reg_sin=reg_q[WIDTH-1].
  - ROTR: reg_ctrl=11, reg_sin=reg_q[0].
  - The counter decrements each RUN cycle. When counter==0, go to DONE.
- DONE:
  - done=1, err per latched op, reg_en=0, reg_ctrl=00, cmd_ready=0.
  - Next state is always IDLE.
- reg_d is 0 outside LOAD RUN cycles. reg_sin is 0 outside shift/rotate RUN cycles.
- All outputs are Moore-decoded from registered state and latched fields. The exceptions are reg_sin and ser_out, which combine the latched op with ser_in/reg_q.

## Timing
- Reset values: state IDLE, counter 0, latched fields 0. Outputs: cmd_ready=1 (from the first cycle after RESET deasserts; commands in RESET cycles are ignored), busy=0, done=0, err=0, reg_en=0, reg_ctrl=00, reg_sin=0, reg_d=0, ser_out_valid=0.
- Command accepted at edge T. RUN occupies cycles T+1 .. T+N, where N = cmd_count+1 for shifts and 1 for LOAD/CLEAR. done is high in cycle T+N+1. cmd_ready returns in cycle T+N+2.
- Minimum command spacing is N+2 cycles. Illegal op: done/err in cycle T+1, ready again at T+2.
- A shift with count=WIDTH-1 (8 steps) fully replaces the register contents. ROTL/ROTR of 8 steps restore the original value.
- cmd_valid held high in RUN/DONE has no effect. The command is not accepted until IDLE.
- RESET during RUN: IDLE at the next edge, no done pulse, reg_en=0 immediately after that edge. The remaining steps are discarded.

## Structure
- Shared package shreg_pkg:
  - op encodings (OP_LOAD..OP_CLEAR), CTRL encodings (CTRL_HOLD, CTRL_SHL, CTRL_LOAD, CTRL_SHR), state enum.
  - Used by this block, the register and the bench.
- Sub-module shreg_step_counter: loadable CNT_W down-counter with load, dec and zero flag.
- Top-level test wrapper instantiates this block with the universal register, CLOCK/RESET shared.

## Test plan
- LOAD cmd_data=0xA5 → one RUN cycle with reg_ctrl=10, reg_en=1; done two cycles after acceptance; reg_q=0xA5.
- After LOAD 0x81, ROTL count=0 → reg_q=0x03. ROTR count=7 from 0x81 → 0x81 after 8 RUN cycles; ser_out sequence 1,0,0,0,0,0,0,1.
- After LOAD 0x00, SHL count=7 with ser_in stream 1,0,1,1,0,0,1,0 → reg_q=0xB2 (first bit ends at MSB); ser_out_valid high exactly 8 cycles.
- cmd_op=6 → done=err=1 in cycle T+1; reg_en never asserted; reg_q unchanged.
- SHR count=7 accepted, RESET asserted in 4th RUN cycle → IDLE next cycle, no done, cmd_ready=1 after RESET drops.
- Back-to-back: cmd_valid held with CLEAR then LOAD 0x3C → second accept exactly 3 cycles after first; final reg_q=0x3C.

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared encodings for the universal shift register and its sequencer:
// command opcodes, register mode select values and sequencer states.
package shreg_pkg;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_SHL   = 3'd1;
  localparam logic [2:0] OP_SHR   = 3'd2;
  localparam logic [2:0] OP_ROTL  = 3'd3;
  localparam logic [2:0] OP_ROTR  = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;

  typedef enum logic [1:0] {
    CTRL_HOLD = 2'b00,
    CTRL_SHL  = 2'b01,
    CTRL_LOAD = 2'b10,
    CTRL_SHR  = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Opcodes 6 and 7 are reserved and rejected without touching the register.
  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_CLEAR;
  endfunction

  function automatic logic op_is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROTL) || (op == OP_ROTR);
  endfunction

  // Register mode used while an operation is running.
  function automatic ctrl_e op_ctrl(input logic [2:0] op);
    ctrl_e c;
    case (op)
      OP_SHL, OP_ROTL:   c = CTRL_SHL;
      OP_SHR, OP_ROTR:   c = CTRL_SHR;
      OP_LOAD, OP_CLEAR: c = CTRL_LOAD;
      default:           c = CTRL_HOLD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/shreg_sequencer_if.sv
// Command handshake and status bundle between the host side and the sequencer.
interface shreg_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data,
    input  cmd_ready, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data,
    output cmd_ready, busy, done, err
  );
endinterface

// File: rtl/shreg_step_counter.sv
// Loadable down-counter tracking the remaining RUN steps; saturates at zero.
module shreg_step_counter #(
  parameter int CNT_W = 3
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  // Load has priority over decrement; never wraps below zero.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/shreg_sequencer.sv
// Command-driven controller for the 8-bit universal shift register.
// Accepts one operation at a time, drives mode/serial/enable for the needed
// number of cycles, generates rotate feedback and pulses done at the end.
module shreg_sequencer
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLOCK,
  input  logic             RESET,
  shreg_sequencer_if.slave cmd,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] reg_q,
  output logic [1:0]       reg_ctrl,
  output logic             reg_sin,
  output logic [WIDTH-1:0] reg_d,
  output logic             reg_en,
  output logic             ser_out,
  output logic             ser_out_valid
);

  state_e           state_reg;
  logic [2:0]       op_reg;
  logic             ready_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             err_reg;
  logic             en_reg;
  ctrl_e            ctrl_reg;
  logic [WIDTH-1:0] d_reg;
  logic             sov_reg;

  logic             accept;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  // Only the end bits of the register feed rotate and ser_out.
  logic unused_q_bits;
  assign unused_q_bits = ^reg_q[WIDTH-2:1];

  // ready is only high in IDLE, so this is valid & ready.
  assign accept       = (state_reg == ST_IDLE) && cmd.cmd_valid;
  assign cnt_load_val = op_is_shift(cmd.cmd_op) ? cmd.cmd_count : '0;

  shreg_step_counter #(.CNT_W(CNT_W)) u_step_counter (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .load     (accept),
    .load_val (cnt_load_val),
    .dec      (state_reg == ST_RUN),
    .zero     (cnt_zero)
  );

  // Sequencer FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      op_reg    <= '0;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      en_reg    <= 1'b0;
      ctrl_reg  <= CTRL_HOLD;
      d_reg     <= '0;
      sov_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_reg    <= cmd.cmd_op;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            if (op_is_legal(cmd.cmd_op)) begin
              state_reg <= ST_RUN;
              en_reg    <= 1'b1;
              ctrl_reg  <= op_ctrl(cmd.cmd_op);
              d_reg     <= (cmd.cmd_op == OP_LOAD) ? cmd.cmd_data : '0;
              sov_reg   <= op_is_shift(cmd.cmd_op);
            end else begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (cnt_zero) begin
            state_reg <= ST_DONE;
            en_reg    <= 1'b0;
            ctrl_reg  <= CTRL_HOLD;
            d_reg     <= '0;
            sov_reg   <= 1'b0;
            done_reg  <= 1'b1;
            err_reg   <= 1'b0;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          err_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          err_reg   <= 1'b0;
          en_reg    <= 1'b0;
          ctrl_reg  <= CTRL_HOLD;
          d_reg     <= '0;
          sov_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Serial input and outgoing bit follow the live ser_in / reg_q during RUN.
  always_comb begin
    reg_sin = 1'b0;
    ser_out = 1'b0;
    if (state_reg == ST_RUN) begin
      case (op_reg)
        OP_SHL:  begin reg_sin = ser_in;         ser_out = reg_q[WIDTH-1]; end
        OP_SHR:  begin reg_sin = ser_in;         ser_out = reg_q[0];       end
        OP_ROTL: begin reg_sin = reg_q[WIDTH-1]; ser_out = reg_q[WIDTH-1]; end
        OP_ROTR: begin reg_sin = reg_q[0];       ser_out = reg_q[0];       end
        default: begin reg_sin = 1'b0;           ser_out = 1'b0;           end
      endcase
    end
  end

  assign cmd.cmd_ready = ready_reg;
  assign cmd.busy      = busy_reg;
  assign cmd.done      = done_reg;
  assign cmd.err       = err_reg;
  assign reg_en        = en_reg;
  assign reg_ctrl      = ctrl_reg;
  assign reg_d         = d_reg;
  assign ser_out_valid = sov_reg;

endmodule

// File: tb/tb_shreg_sequencer.sv
// Self-checking bench for shreg_sequencer: a behavioural universal register,
// a table of directed commands, hand-written reset/back-to-back sequences and
// random commands checked against an arithmetic reference model.
module tb_shreg_sequencer;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       ser_in = 1'b0;
  logic [7:0] reg_q;
  logic [1:0] reg_ctrl;
  logic       reg_sin;
  logic [7:0] reg_d;
  logic       reg_en;
  logic       ser_out;
  logic       ser_out_valid;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] cur_q;

  shreg_sequencer_if #(.WIDTH(8), .CNT_W(3)) bus ();

  shreg_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .cmd           (bus.slave),
    .ser_in        (ser_in),
    .reg_q         (reg_q),
    .reg_ctrl      (reg_ctrl),
    .reg_sin       (reg_sin),
    .reg_d         (reg_d),
    .reg_en        (reg_en),
    .ser_out       (ser_out),
    .ser_out_valid (ser_out_valid)
  );

  always #5 CLOCK = ~CLOCK;

  // Universal shift register driven by the sequencer.
  always_ff @(posedge CLOCK) begin
    if (RESET) reg_q <= 8'h00;
    else if (reg_en) begin
      case (reg_ctrl)
        2'b01:   reg_q <= {reg_q[6:0], reg_sin};
        2'b10:   reg_q <= reg_d;
        2'b11:   reg_q <= {reg_sin, reg_q[7:1]};
        default: reg_q <= reg_q;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Final register value after a whole operation, from plain arithmetic.
  // stream[k] is the serial bit presented in the k-th RUN cycle.
  function automatic logic [7:0] model(input logic [2:0] op, input int cnt,
                                       input logic [7:0] q, input logic [7:0] d,
                                       input logic [7:0] stream);
    int n = cnt + 1;
    int qi = int'(q);
    int s = 0;
    case (op)
      3'd0: return d;
      3'd5: return 8'h00;
      3'd1: begin
        for (int k = 0; k < n; k++) s = s * 2 + int'(stream[k]);
        return 8'((qi << n) | s);
      end
      3'd2: begin
        for (int k = 0; k < n; k++) s = s + (int'(stream[k]) << (8 - n + k));
        return 8'((qi >> n) | s);
      end
      3'd3: return 8'((qi << n) | (qi >> (8 - n)));
      3'd4: return 8'((qi >> n) | (qi << (8 - n)));
      default: return q;
    endcase
  endfunction

  function automatic logic [1:0] exp_ctrl(input logic [2:0] op);
    case (op)
      3'd1, 3'd3: return 2'b01;
      3'd2, 3'd4: return 2'b11;
      3'd0, 3'd5: return 2'b10;
      default:    return 2'b00;
    endcase
  endfunction

  // Issue one command from the IDLE cycle and check every cycle until ready returns.
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [2:0] cnt,
                        input logic [7:0] d, input logic [7:0] stream, input logic [7:0] exp_q);
    bit legal = (op <= 3'd5);
    bit sh = (op >= 3'd1) && (op <= 3'd4);
    int n = !legal ? 0 : (sh ? int'(cnt) + 1 : 1);
    logic so;
    chk({tag, "_ready_idle"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_count = cnt; bus.cmd_data = d;
    @(posedge CLOCK); #1;
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      ser_in = stream[k];
      #1;
      chk($sformatf("%s_run%0d_en", tag, k), 32'(reg_en), 32'd1);
      chk($sformatf("%s_run%0d_ctrl", tag, k), 32'(reg_ctrl), 32'(exp_ctrl(op)));
      chk($sformatf("%s_run%0d_sov", tag, k), 32'(ser_out_valid), 32'(sh));
      chk($sformatf("%s_run%0d_d", tag, k), 32'(reg_d), (op == 3'd0) ? 32'(d) : 32'd0);
      chk($sformatf("%s_run%0d_status", tag, k),
          {29'd0, bus.busy, bus.done, bus.cmd_ready}, 32'b100);
      if (sh) begin
        so = (op == 3'd1 || op == 3'd3) ? cur_q[7 - k] : cur_q[k];
        chk($sformatf("%s_run%0d_ser_out", tag, k), 32'(ser_out), 32'(so));
        chk($sformatf("%s_run%0d_sin", tag, k), 32'(reg_sin),
            (op == 3'd3 || op == 3'd4) ? 32'(so) : 32'(stream[k]));
      end else begin
        chk($sformatf("%s_run%0d_sin", tag, k), 32'(reg_sin), 32'd0);
      end
      @(posedge CLOCK); #1;
    end
    ser_in = 1'b0;
    chk({tag, "_done"}, {28'd0, bus.done, bus.err, reg_en, bus.cmd_ready}, {28'd0, 1'b1, !legal, 2'b00});
    chk({tag, "_done_ctrl"}, 32'(reg_ctrl), 32'd0);
    @(posedge CLOCK); #1;
    chk({tag, "_after"}, {29'd0, bus.done, bus.busy, bus.cmd_ready}, 32'b001);
    chk({tag, "_reg_q"}, 32'(reg_q), 32'(exp_q));
    cur_q = exp_q;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [2:0] cnt;
    logic [7:0] d;
    logic [7:0] stream;
    logic [7:0] exp_q;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{3'd0, 3'd0, 8'hA5, 8'h00, 8'hA5};
    tbl[1]  = '{3'd0, 3'd0, 8'h81, 8'h00, 8'h81};
    tbl[2]  = '{3'd3, 3'd0, 8'h00, 8'h00, 8'h03};
    tbl[3]  = '{3'd0, 3'd0, 8'h81, 8'h00, 8'h81};
    tbl[4]  = '{3'd4, 3'd7, 8'h00, 8'h00, 8'h81};
    tbl[5]  = '{3'd0, 3'd0, 8'h00, 8'h00, 8'h00};
    tbl[6]  = '{3'd1, 3'd7, 8'hFF, 8'h4D, 8'hB2};
    tbl[7]  = '{3'd6, 3'd2, 8'h11, 8'hFF, 8'hB2};
    tbl[8]  = '{3'd7, 3'd5, 8'h22, 8'hFF, 8'hB2};
    tbl[9]  = '{3'd5, 3'd3, 8'h77, 8'hFF, 8'h00};
    tbl[10] = '{3'd0, 3'd0, 8'h5A, 8'h00, 8'h5A};
    tbl[11] = '{3'd2, 3'd3, 8'h00, 8'h0F, 8'hF5};

    // Reset with a command pending: must be ignored.
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_count = 3'd0; bus.cmd_data = 8'hEE;
    repeat (3) @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("reset_status", {28'd0, bus.cmd_ready, bus.busy, bus.done, bus.err}, 32'b1000);
    chk("reset_reg_if", {25'd0, reg_en, reg_ctrl, reg_sin, ser_out_valid, ser_out}, 32'd0);
    chk("reset_reg_d", 32'(reg_d), 32'd0);
    cur_q = 8'h00;

    for (int i = 0; i < 12; i++)
      do_cmd($sformatf("tbl%0d", i), tbl[i].op, tbl[i].cnt, tbl[i].d, tbl[i].stream, tbl[i].exp_q);

    // RESET in the 4th RUN cycle of an 8-step SHR.
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd2; bus.cmd_count = 3'd7; bus.cmd_data = 8'h00;
    @(posedge CLOCK); #1;
    bus.cmd_valid = 1'b0;
    repeat (3) begin @(posedge CLOCK); #1; end
    chk("rst_run_active", {30'd0, bus.busy, reg_en}, 32'b11);
    RESET = 1'b1;
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    chk("rst_run_idle", {28'd0, bus.busy, reg_en, bus.done, bus.cmd_ready}, 32'b0001);
    @(posedge CLOCK); #1;
    chk("rst_run_after", {29'd0, bus.busy, bus.done, bus.cmd_ready}, 32'b001);
    chk("rst_run_reg_q", 32'(reg_q), 32'd0);
    cur_q = 8'h00;

    // Back-to-back with cmd_valid held: CLEAR then LOAD 0x3C.
    begin
      int first = -1;
      int second = -1;
      logic was_ready;
      bus.cmd_valid = 1'b1; bus.cmd_op = 3'd5; bus.cmd_data = 8'h00;
      for (int c = 0; c < 20 && second < 0; c++) begin
        was_ready = bus.cmd_ready;
        @(posedge CLOCK); #1;
        if (was_ready) begin
          if (first < 0) begin
            first = c; bus.cmd_op = 3'd0; bus.cmd_data = 8'h3C;
          end else begin
            second = c; bus.cmd_valid = 1'b0;
          end
        end
      end
      chk("b2b_spacing", 32'(second - first), 32'd3);
      repeat (2) begin @(posedge CLOCK); #1; end
      chk("b2b_ready", 32'(bus.cmd_ready), 32'd1);
      chk("b2b_reg_q", 32'(reg_q), 32'h3C);
      cur_q = 8'h3C;
    end

    // Random commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [2:0] cnt;
      logic [7:0] d;
      logic [7:0] st;
      op  = 3'($urandom_range(0, 7));
      cnt = 3'($urandom_range(0, 7));
      d   = 8'($urandom);
      st  = 8'($urandom);
      do_cmd($sformatf("rnd%0d", i), op, cnt, d, st, model(op, int'(cnt), cur_q, d, st));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
